// File: rtl/frame_decode_if.sv
// ISO14443A sequence types and the frame_decode bus interface.
//
// ISO14443A_pkg::PCDBitSequence - one decoded PCD sequence (X, Y, Z, ERROR).
//
// frame_decode_if groups the sequence input side and the decoded frame
// output side of frame_decode.
//   seq, seq_valid, idle    : from sequence_decode
//   soc, eoc, error         : one-cycle frame event pulses
//   data, data_valid        : decoded frame bit and its strobe
//   bit_count               : data bits emitted since the last soc
// modport master drives the sequence side; modport slave is the decoder.

package ISO14443A_pkg;
  typedef enum logic [1:0] {
    SEQ_X     = 2'd0,
    SEQ_Y     = 2'd1,
    SEQ_Z     = 2'd2,
    SEQ_ERROR = 2'd3
  } PCDBitSequence;
endpackage

interface frame_decode_if;
  import ISO14443A_pkg::*;

  PCDBitSequence seq;
  logic          seq_valid;
  logic          idle;
  logic          soc;
  logic          eoc;
  logic          data;
  logic          data_valid;
  logic          error;
  logic [9:0]    bit_count;

  modport master (
    output seq, seq_valid, idle,
    input  soc, eoc, data, data_valid, error, bit_count
  );

  modport slave (
    input  seq, seq_valid, idle,
    output soc, eoc, data, data_valid, error, bit_count
  );
endinterface

// File: rtl/frame_decode.sv
// frame_decode - turns the ISO14443A PCD sequence stream (X/Y/Z/ERROR)
// into start/end-of-communication events and a stream of frame bits.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : frame_decode_if.slave
//          in : seq, seq_valid, idle
//          out: soc, eoc, data, data_valid, error, bit_count (all registered)
//
// Every response is registered and appears exactly one cycle after the
// seq_valid (or idle) cycle that caused it.

module frame_decode
  import ISO14443A_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  frame_decode_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SOC_SEEN,
    DATA,
    WAIT_IDLE
  } state_t;

  localparam logic [9:0] COUNT_MAX = 10'd1023;

  state_t     state, state_nxt;
  logic       pending, pending_nxt;
  logic       prev_x, prev_x_nxt;
  logic       soc_q, soc_nxt;
  logic       eoc_q, eoc_nxt;
  logic       err_q, err_nxt;
  logic       dv_q, dv_nxt;
  logic       data_q, data_nxt;
  logic [9:0] count_q, count_nxt;
  logic       emit;

  assign bus.soc        = soc_q;
  assign bus.eoc        = eoc_q;
  assign bus.error      = err_q;
  assign bus.data_valid = dv_q;
  assign bus.data       = data_q;
  assign bus.bit_count  = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      prev_x  <= 1'b0;
      soc_q   <= 1'b0;
      eoc_q   <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= 1'b0;
      count_q <= 10'd0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      prev_x  <= prev_x_nxt;
      soc_q   <= soc_nxt;
      eoc_q   <= eoc_nxt;
      err_q   <= err_nxt;
      dv_q    <= dv_nxt;
      data_q  <= data_nxt;
      count_q <= count_nxt;
    end
  end

  // Each decoded bit is parked in 'pending' and only emitted when the next
  // sequence shows it was not the closing logic 0 of the EOC pattern.
  // prev_x remembers whether the last accepted sequence was X, because
  // Z directly after X is an illegal coding.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    prev_x_nxt  = prev_x;
    soc_nxt     = 1'b0;
    eoc_nxt     = 1'b0;
    err_nxt     = 1'b0;
    dv_nxt      = 1'b0;
    data_nxt    = 1'b0;
    count_nxt   = count_q;
    emit        = 1'b0;

    case (state)
      IDLE: begin
        if (bus.seq_valid && bus.seq == SEQ_Z) begin
          soc_nxt     = 1'b1;
          count_nxt   = 10'd0;
          pending_nxt = 1'b0;
          prev_x_nxt  = 1'b0;
          state_nxt   = SOC_SEEN;
        end
      end

      SOC_SEEN: begin
        if (bus.seq_valid) begin
          case (bus.seq)
            SEQ_X: begin
              pending_nxt = 1'b1;
              prev_x_nxt  = 1'b1;
              state_nxt   = DATA;
            end
            SEQ_Z: begin
              pending_nxt = 1'b0;
              prev_x_nxt  = 1'b0;
              state_nxt   = DATA;
            end
            default: begin
              err_nxt     = 1'b1;
              pending_nxt = 1'b0;
              state_nxt   = WAIT_IDLE;
            end
          endcase
        end else if (bus.idle) begin
          err_nxt     = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end

      DATA: begin
        if (bus.seq_valid) begin
          case (bus.seq)
            SEQ_X: begin
              emit        = 1'b1;
              pending_nxt = 1'b1;
              prev_x_nxt  = 1'b1;
            end
            SEQ_Z: begin
              if (prev_x) begin
                err_nxt     = 1'b1;
                pending_nxt = 1'b0;
                state_nxt   = WAIT_IDLE;
              end else begin
                emit        = 1'b1;
                pending_nxt = 1'b0;
                prev_x_nxt  = 1'b0;
              end
            end
            SEQ_Y: begin
              // Y with a pending 0 is the EOC pattern; that 0 is not data.
              if (pending) begin
                emit        = 1'b1;
                pending_nxt = 1'b0;
                prev_x_nxt  = 1'b0;
              end else begin
                eoc_nxt     = 1'b1;
                pending_nxt = 1'b0;
                prev_x_nxt  = 1'b0;
                state_nxt   = IDLE;
              end
            end
            default: begin
              err_nxt     = 1'b1;
              pending_nxt = 1'b0;
              state_nxt   = WAIT_IDLE;
            end
          endcase
        end else if (bus.idle) begin
          err_nxt     = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end

      WAIT_IDLE: begin
        if (bus.idle) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Emitting releases the bit held before this sequence arrived.
    if (emit) begin
      dv_nxt   = 1'b1;
      data_nxt = pending;
      if (count_q != COUNT_MAX) begin
        count_nxt = count_q + 10'd1;
      end
    end
  end

endmodule

// File: doc/frame_decode.md
FRAME_DECODE -- requirements
Module: frame_decode

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 seq  input  PCDBitSequence (ISO14443A_pkg)  decoded sequence from sequence_decode (X, Y, Z, ERROR).
REQ-004 seq_valid  input  1  seq valid this cycle; single-cycle pulse.
REQ-005 idle  input  1  sequence_decode idle flag, high between frames.
REQ-006 soc  output  1  one-cycle pulse: start of communication detected.
REQ-007 eoc  output  1  one-cycle pulse: valid end of communication detected.
REQ-008 data  output  1  decoded data bit; meaningful only with data_valid.
REQ-009 data_valid  output  1  one-cycle pulse: data holds the next frame bit.
REQ-010 error  output  1  one-cycle pulse: protocol violation, frame aborted.
REQ-011 bit_count  output  10  data bits emitted since last soc; saturates at 1023.

Function
REQ-012 All outputs SHALL be registered; each response SHALL appear exactly 1 cycle after the seq_valid (or idle) cycle causing it.
REQ-013 States SHALL be IDLE, SOC_SEEN, DATA, WAIT_IDLE.
REQ-014 IDLE: seq_valid with Z -> soc pulse, bit_count cleared to 0, go SOC_SEEN; any other seq ignored, no output.
REQ-015 Decoding: X = logic 1; Z = logic 0; Y after X = logic 0; each decoded bit SHALL be held as a 1-bit pending bit until the next sequence arrives, never emitted immediately.
REQ-016 SOC_SEEN: X -> pending=1, go DATA; Z -> pending=0, go DATA; Y or ERROR -> error pulse, go WAIT_IDLE.
REQ-017 DATA, X arrives: if previous seq was X or pending=1, emit pending, pending=1; if pending=0 (from Z or Y), emit pending, pending=1.
REQ-018 DATA, Z arrives: if previous seq was X -> error pulse, go WAIT_IDLE; otherwise emit pending, pending=0.
REQ-019 DATA, Y arrives: if pending=1 -> emit 1, pending=0; if pending=0 -> eoc pulse, pending discarded (it is the EOC logic 0), go IDLE.
REQ-020 DATA, ERROR arrives -> error pulse, pending discarded, go WAIT_IDLE.
REQ-021 Emit = data_valid pulse with data=pending bit, bit_count incremented by 1 (saturating at 1023) on the same cycle.
REQ-022 DATA or SOC_SEEN, idle rises with no seq_valid that cycle -> error pulse, go IDLE.
REQ-023 WAIT_IDLE: all seq ignored, no outputs; when idle=1 go IDLE (soc accepted from the next seq_valid Z).
REQ-024 At most one of soc, eoc, error SHALL be high in any cycle; data_valid SHALL never coincide with eoc or error.
REQ-025 bit_count SHALL hold its value after eoc/error until the next soc.

Reset
REQ-026 While rst=1, at the next clock edge: state IDLE, pending=0, soc=eoc=data=data_valid=error=0, bit_count=0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no eoc or error pulse; the following X/Y sequences SHALL be ignored until a Z.

Verification
REQ-028 Z X Y Y -> soc; one data_valid with data=1; eoc; bit_count=1; no error.
REQ-029 Z Z X Y Y -> soc; data 0 then 1; eoc on the final Y; bit_count=2.
REQ-030 Z X Y Z Y -> soc; data 1 then 0; eoc on the final Y; bit_count=2.
REQ-031 Z X ERROR, then Z X while idle=0 -> error once; no eoc; the later Z X is ignored; after idle=1, Z -> soc.
REQ-032 Z Y -> soc then error; no data_valid; bit_count=0.
REQ-033 Z X X, rst 1 cycle, then X Y Y -> all outputs 0 the cycle after rst; no soc/data/eoc until the next Z.
